// File: rtl/cache_mem_arbiter_if.sv
// Bus bundle between the two caches, the RAM port and the arbiter.
// slave  : the arbiter's view (requests and RAM status in, stalls/data/RAM controls out)
// master : the view of whatever drives the requests and models the RAM
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ERR_W  = 8
);
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              iwait;
  logic [DATA_W-1:0] iload;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              dwait;
  logic [DATA_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  logic [1:0]        ramstate;
  logic              ram_err;
  logic [ERR_W-1:0]  err_cnt;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ram_err, err_cnt
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ram_err, err_cnt
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Single-word icache/dcache arbiter onto one RAM port.
// dcache has priority; the icache is forced through after STARVE_MAX
// consecutive dcache words completed while it was waiting.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no grant; RAM enables low; arbitration happens here
// D_ACC | dcache owns the RAM port until ACCESS or withdrawal
// I_ACC | icache owns the RAM port until ACCESS or withdrawal
module cache_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int ERR_W      = 8
) (
  input logic                  CLK,
  input logic                  RST,
  cache_mem_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, D_ACC = 2'd1, I_ACC = 2'd2} state_t;

  localparam logic [1:0]      RS_ACCESS = 2'd2;
  localparam logic [1:0]      RS_ERROR  = 2'd3;
  localparam int              SC_W      = $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0] SC_MAX    = SC_W'(STARVE_MAX);

  state_t            state, state_nxt;
  logic [SC_W-1:0]   starve_cnt, starve_nxt;
  logic              ram_err_q;
  logic [ERR_W-1:0]  err_cnt_q;
  logic              d_req, force_i, access, error_hit;

  assign d_req     = bus.dREN | bus.dWEN;
  assign force_i   = bus.iREN && (starve_cnt == SC_MAX);
  assign access    = (bus.ramstate == RS_ACCESS);
  assign error_hit = (state != IDLE) && (bus.ramstate == RS_ERROR);

  assign bus.ram_err = ram_err_q;
  assign bus.err_cnt = err_cnt_q;

  // Grant register and icache starvation counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Sticky error flag and saturating count of ERROR cycles seen under a grant.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ram_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else if (error_hit) begin
      ram_err_q <= 1'b1;
      if (err_cnt_q != {ERR_W{1'b1}}) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  // Next grant; a withdrawn request releases the port without completing.
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    unique case (state)
      IDLE: begin
        if (d_req && !force_i) state_nxt = D_ACC;
        else if (bus.iREN)     state_nxt = I_ACC;
      end
      D_ACC: begin
        if (!d_req) begin
          state_nxt = IDLE;
        end else if (access) begin
          state_nxt = IDLE;
          if (!bus.iREN)               starve_nxt = '0;
          else if (starve_cnt != SC_MAX) starve_nxt = starve_cnt + 1'b1;
        end
      end
      I_ACC: begin
        if (!bus.iREN) begin
          state_nxt = IDLE;
        end else if (access) begin
          state_nxt  = IDLE;
          starve_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // RAM controls and cache responses decoded from the grant and live inputs.
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = {ADDR_W{1'b0}};
    bus.ramstore = {DATA_W{1'b0}};
    bus.iwait    = 1'b1;
    bus.iload    = {DATA_W{1'b0}};
    bus.dwait    = 1'b1;
    bus.dload    = {DATA_W{1'b0}};
    unique case (state)
      D_ACC: begin
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        if (d_req && access) begin
          bus.dwait = 1'b0;
          bus.dload = bus.ramload;
        end
      end
      I_ACC: begin
        bus.ramaddr = bus.iaddr;
        bus.ramREN  = 1'b1;
        if (bus.iREN && access) begin
          bus.iwait = 1'b0;
          bus.iload = bus.ramload;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios followed by
// randomized traffic, all outputs compared against a word-level owner model.
module tb_cache_mem_arbiter;
  localparam int ADDR_W = 32, DATA_W = 32, STARVE_MAX = 4, ERR_W = 8;
  localparam int ERR_SAT = (1 << ERR_W) - 1;

  logic CLK, RST;
  int n_checks = 0;
  int n_fail   = 0;

  // who currently owns the RAM port: 0 nobody, 1 dcache, 2 icache
  int m_owner;
  int m_dwins;     // dcache words won while the icache was kept waiting
  bit m_err;
  int m_errs;

  cache_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ERR_W(ERR_W)) bus ();

  cache_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX), .ERR_W(ERR_W))
    dut (.CLK(CLK), .RST(RST), .bus(bus.slave));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_dwins = 0; m_err = 0; m_errs = 0;
  endtask

  // Word-level rules applied at each rising edge with the inputs present before it.
  task automatic model_edge();
    bit dq, acc;
    if (RST) begin
      model_reset();
      return;
    end
    dq  = bus.dREN || bus.dWEN;
    acc = (bus.ramstate == 2'd2);
    if (m_owner != 0 && bus.ramstate == 2'd3) begin
      m_err = 1;
      if (m_errs < ERR_SAT) m_errs++;
    end
    if (m_owner == 0) begin
      if (dq && !(bus.iREN && m_dwins == STARVE_MAX)) m_owner = 1;
      else if (bus.iREN)                               m_owner = 2;
    end else if (m_owner == 1) begin
      if (!dq) m_owner = 0;
      else if (acc) begin
        m_owner = 0;
        m_dwins = bus.iREN ? ((m_dwins < STARVE_MAX) ? m_dwins + 1 : STARVE_MAX) : 0;
      end
    end else begin
      if (!bus.iREN) m_owner = 0;
      else if (acc) begin
        m_owner = 0;
        m_dwins = 0;
      end
    end
  endtask

  task automatic check_all();
    logic [31:0] e_addr, e_store, e_iload, e_dload;
    bit e_ren, e_wen, e_iw, e_dw, dq, acc;
    dq = bus.dREN || bus.dWEN;
    acc = (bus.ramstate == 2'd2);
    e_addr = 0; e_store = 0; e_iload = 0; e_dload = 0;
    e_ren = 0; e_wen = 0; e_iw = 1; e_dw = 1;
    if (m_owner == 1) begin
      e_addr = bus.daddr; e_store = bus.dstore;
      e_wen = bus.dWEN; e_ren = bus.dREN && !bus.dWEN;
      if (dq && acc) begin e_dw = 0; e_dload = bus.ramload; end
    end else if (m_owner == 2) begin
      e_addr = bus.iaddr; e_ren = 1;
      if (bus.iREN && acc) begin e_iw = 0; e_iload = bus.ramload; end
    end
    check_eq("ramREN",   bus.ramREN,   e_ren);
    check_eq("ramWEN",   bus.ramWEN,   e_wen);
    check_eq("ramaddr",  bus.ramaddr,  e_addr);
    check_eq("ramstore", bus.ramstore, e_store);
    check_eq("iwait",    bus.iwait,    e_iw);
    check_eq("iload",    bus.iload,    e_iload);
    check_eq("dwait",    bus.dwait,    e_dw);
    check_eq("dload",    bus.dload,    e_dload);
    check_eq("ram_err",  bus.ram_err,  m_err);
    check_eq("err_cnt",  bus.err_cnt,  m_errs);
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic settle();
    #1;
    check_all();
  endtask

  task automatic go_idle();
    bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0; bus.ramstate = 2'd0;
    settle();
    tick();
    settle();
  endtask

  int i_words;

  initial begin
    RST = 1;
    bus.iREN = 1; bus.dREN = 1; bus.dWEN = 0;
    bus.iaddr = 32'h200; bus.daddr = 32'h100; bus.dstore = 0;
    bus.ramload = 0; bus.ramstate = 2'd0;
    model_reset();

    // reset with both requests pending
    repeat (3) begin
      tick();
      settle();
      check_eq("rst_ramREN", bus.ramREN, 0);
      check_eq("rst_dwait",  bus.dwait,  1);
      check_eq("rst_iwait",  bus.iwait,  1);
    end
    RST = 0;
    settle();
    tick();
    settle();
    check_eq("rst_first_grant_d", bus.ramaddr, 32'h100);
    go_idle();

    // icache read, zero-wait RAM
    bus.iREN = 1; bus.iaddr = 32'h40;
    settle();
    tick();
    bus.ramstate = 2'd2; bus.ramload = 32'h2108_0004;
    settle();
    check_eq("iread_iload", bus.iload, 32'h2108_0004);
    check_eq("iread_iwait", bus.iwait, 0);
    tick();
    bus.iREN = 0;
    settle();
    check_eq("iread_idle_addr", bus.ramaddr, 0);
    go_idle();

    // dcache write with three BUSY cycles
    bus.dWEN = 1; bus.daddr = 32'h3F00; bus.dstore = 32'hDEAD_BEEF; bus.ramstate = 2'd1;
    settle();
    tick();
    for (int k = 0; k < 4; k++) begin
      bus.ramstate = (k < 3) ? 2'd1 : 2'd2;
      settle();
      check_eq("dwr_ramWEN",   bus.ramWEN,   1);
      check_eq("dwr_ramREN",   bus.ramREN,   0);
      check_eq("dwr_ramaddr",  bus.ramaddr,  32'h3F00);
      check_eq("dwr_ramstore", bus.ramstore, 32'hDEAD_BEEF);
      check_eq("dwr_dwait",    bus.dwait,    (k < 3));
      tick();
    end
    go_idle();

    // continuous contention, zero-wait RAM
    bus.dREN = 1; bus.iREN = 1; bus.daddr = 32'h100; bus.iaddr = 32'h200;
    bus.ramstate = 2'd2; bus.ramload = 32'h5555_AAAA;
    settle();
    i_words = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      settle();
      check_eq("cont_grant", bus.ramaddr, (n % 5 == 4) ? 32'h200 : 32'h100);
      check_eq("cont_dwait", bus.dwait, (n % 5 == 4));
      if (!bus.iwait) i_words++;
      tick();
      settle();
      check_eq("cont_idle", bus.ramREN, 0);
    end
    check_eq("cont_i_words", i_words, 2);
    go_idle();

    // ERROR twice then ACCESS on a dcache read
    bus.dREN = 1; bus.daddr = 32'h300; bus.ramstate = 2'd3;
    settle();
    tick();
    settle();
    check_eq("err_dwait0", bus.dwait, 1);
    tick();
    settle();
    check_eq("err_dwait1", bus.dwait, 1);
    check_eq("err_flag1",  bus.ram_err, 1);
    tick();
    bus.ramstate = 2'd2; bus.ramload = 32'hCAFE_F00D;
    settle();
    check_eq("err_dload", bus.dload, 32'hCAFE_F00D);
    check_eq("err_dwait", bus.dwait, 0);
    check_eq("err_cnt2",  bus.err_cnt, 2);
    tick();
    go_idle();

    // withdrawal during BUSY, then reset in the middle of an icache grant
    bus.dREN = 1; bus.daddr = 32'h380; bus.ramstate = 2'd1;
    settle();
    tick();
    settle();
    check_eq("wd_granted", bus.ramREN, 1);
    bus.dREN = 0;
    settle();
    check_eq("wd_no_pulse", bus.dwait, 1);
    tick();
    settle();
    check_eq("wd_idle_addr", bus.ramaddr, 0);
    bus.iREN = 1; bus.iaddr = 32'h440;
    settle();
    tick();
    settle();
    check_eq("mr_granted", bus.ramREN, 1);
    RST = 1;
    model_reset();
    settle();
    check_eq("mr_ramREN",  bus.ramREN,  0);
    check_eq("mr_ramaddr", bus.ramaddr, 0);
    check_eq("mr_iwait",   bus.iwait,   1);
    check_eq("mr_err_cnt", bus.err_cnt, 0);
    tick();
    RST = 0; bus.dREN = 1;
    settle();
    tick();
    settle();
    check_eq("mr_first_grant_d", bus.ramaddr, 32'h380);
    go_idle();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int r;
      tick();
      RST = ($urandom_range(0, 199) == 0);
      if (RST) model_reset();
      bus.iREN   = ($urandom_range(0, 9) < 6);
      bus.dREN   = ($urandom_range(0, 9) < 4);
      bus.dWEN   = ($urandom_range(0, 9) < 3);
      bus.iaddr  = $urandom;
      bus.daddr  = $urandom;
      bus.dstore = $urandom;
      bus.ramload = $urandom;
      r = $urandom_range(0, 99);
      bus.ramstate = (r < 15) ? 2'd0 : (r < 40) ? 2'd1 : (r < 80) ? 2'd2 : 2'd3;
      settle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
